// File: rtl/bypass_select_tracker.sv
// rtl/bypass_select_tracker.sv - bypass select generator tracking in-flight producer tags
module bypass_select_tracker #(
  parameter int NUM_LANES       = 4,
  parameter int NUM_STAGES      = 2,
  parameter int NUM_CONSUMERS   = 4,
  parameter int NUM_OPERANDS    = 3,
  parameter int TAG_WIDTH       = 7,
  parameter int ZERO_TAG_BYPASS = 0,
  localparam int LANE_BITS  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
  localparam int STAGE_BITS = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1,
  localparam int NOPS       = NUM_CONSUMERS * NUM_OPERANDS
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            stall,
  input  logic                            flush,
  input  logic [NUM_LANES-1:0]            prod_valid,
  input  logic [NUM_LANES*TAG_WIDTH-1:0]  prod_tag,
  input  logic [NOPS-1:0]                 cons_valid,
  input  logic [NOPS*TAG_WIDTH-1:0]       cons_tag,
  output logic [NOPS-1:0]                 sel_valid,
  output logic [NOPS*STAGE_BITS-1:0]      sel_stage,
  output logic [NOPS*LANE_BITS-1:0]       sel_lane,
  output logic                            multi_hit
);

  // The oldest stage is never compared against (its entries leave next cycle),
  // so only stages 0..NUM_STAGES-2 need storage.
  localparam int HELD = (NUM_STAGES > 1) ? NUM_STAGES - 1 : 1;

  logic [HELD-1:0][NUM_LANES-1:0]                       ent_valid;
  logic [HELD-1:0][NUM_LANES-1:0][TAG_WIDTH-1:0]        ent_tag;
  logic [NUM_STAGES-1:0][NUM_LANES-1:0]                 nxt_valid;
  logic [NUM_STAGES-1:0][NUM_LANES-1:0][TAG_WIDTH-1:0]  nxt_tag;

  logic [NOPS-1:0]            sel_valid_d;
  logic [NOPS*STAGE_BITS-1:0] sel_stage_d;
  logic [NOPS*LANE_BITS-1:0]  sel_lane_d;
  logic                       multi_hit_d;

  // Tag 0 is the hard-wired zero register unless bypassing it is enabled
  function automatic logic tag_ok(input logic [TAG_WIDTH-1:0] t);
    return (ZERO_TAG_BYPASS != 0) || (t != '0);
  endfunction

  // Occupancy of every stage during the next cycle: producers enter stage 0
  always_comb begin
    nxt_valid = '0;
    nxt_tag   = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      nxt_valid[0][l] = prod_valid[l];
      nxt_tag[0][l]   = prod_tag[l*TAG_WIDTH +: TAG_WIDTH];
    end
    for (int s = 1; s < NUM_STAGES; s++) begin
      nxt_valid[s] = ent_valid[s-1];
      nxt_tag[s]   = ent_tag[s-1];
    end
  end

  // Per-operand select; scanning oldest-to-youngest lets the youngest stage, lowest lane win
  always_comb begin
    sel_valid_d = '0;
    sel_stage_d = '0;
    sel_lane_d  = '0;
    for (int k = 0; k < NOPS; k++) begin
      for (int s = NUM_STAGES - 1; s >= 0; s--) begin
        for (int l = NUM_LANES - 1; l >= 0; l--) begin
          if (cons_valid[k] && nxt_valid[s][l] &&
              (nxt_tag[s][l] == cons_tag[k*TAG_WIDTH +: TAG_WIDTH]) &&
              tag_ok(nxt_tag[s][l])) begin
            sel_valid_d[k]                          = 1'b1;
            sel_stage_d[k*STAGE_BITS +: STAGE_BITS] = STAGE_BITS'(s);
            sel_lane_d[k*LANE_BITS +: LANE_BITS]    = LANE_BITS'(l);
          end
        end
      end
    end
  end

  // Duplicate live tag within one stage of the next-cycle set
  always_comb begin
    multi_hit_d = 1'b0;
    for (int s = 0; s < NUM_STAGES; s++) begin
      for (int a = 0; a < NUM_LANES; a++) begin
        for (int b = a + 1; b < NUM_LANES; b++) begin
          if (nxt_valid[s][a] && nxt_valid[s][b] &&
              (nxt_tag[s][a] == nxt_tag[s][b]) && tag_ok(nxt_tag[s][a])) begin
            multi_hit_d = 1'b1;
          end
        end
      end
    end
  end

  // Pipeline shift and select registers; reset > flush > stall
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_valid <= '0;
      ent_tag   <= '0;
      sel_valid <= '0;
      sel_stage <= '0;
      sel_lane  <= '0;
      multi_hit <= 1'b0;
    end else if (flush) begin
      ent_valid <= '0;
      sel_valid <= '0;
      sel_stage <= '0;
      sel_lane  <= '0;
    end else if (!stall) begin
      for (int s = 0; s < HELD; s++) begin
        ent_valid[s] <= nxt_valid[s];
        ent_tag[s]   <= nxt_tag[s];
      end
      sel_valid <= sel_valid_d;
      sel_stage <= sel_stage_d;
      sel_lane  <= sel_lane_d;
      multi_hit <= multi_hit | multi_hit_d;
    end
  end

endmodule

// File: tb/tb_bypass_select_tracker.sv
// tb/tb_bypass_select_tracker.sv - directed vector bench for bypass_select_tracker
module tb_bypass_select_tracker;

  localparam int NL = 4;
  localparam int TW = 7;
  localparam int NOPS = 12;
  localparam int SB = 1;
  localparam int LB = 2;

  logic clk = 1'b0;
  logic rst, stall, flush;
  logic [NL-1:0]      prod_valid;
  logic [NL*TW-1:0]   prod_tag;
  logic [NOPS-1:0]    cons_valid;
  logic [NOPS*TW-1:0] cons_tag;

  logic [NOPS-1:0]    sv0, sv1;
  logic [NOPS*SB-1:0] st0, st1;
  logic [NOPS*LB-1:0] ln0, ln1;
  logic               mh0, mh1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bypass_select_tracker dut0 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .prod_valid(prod_valid), .prod_tag(prod_tag),
    .cons_valid(cons_valid), .cons_tag(cons_tag),
    .sel_valid(sv0), .sel_stage(st0), .sel_lane(ln0), .multi_hit(mh0)
  );

  bypass_select_tracker #(.ZERO_TAG_BYPASS(1)) dut1 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .prod_valid(prod_valid), .prod_tag(prod_tag),
    .cons_valid(cons_valid), .cons_tag(cons_tag),
    .sel_valid(sv1), .sel_stage(st1), .sel_lane(ln1), .multi_hit(mh1)
  );

  typedef struct {
    logic        stall;
    logic        flush;
    logic [3:0]  pv;
    logic [6:0]  ptag;
    int          ck;
    logic [6:0]  ctag;
    int          ek;
    logic        esv;
    int          est;
    int          eln;
    logic        zsv;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(input logic s, input logic f, input logic [3:0] pv,
                              input logic [6:0] pt, input int ck, input logic [6:0] ct,
                              input int ek, input logic esv, input int est,
                              input int eln, input logic zsv);
    vec_t v;
    v.stall = s; v.flush = f; v.pv = pv; v.ptag = pt; v.ck = ck; v.ctag = ct;
    v.ek = ek; v.esv = esv; v.est = est; v.eln = eln; v.zsv = zsv;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=0x%0h expected=0x%0h", name, idx, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // All lanes carry the same tag so a DUT ignoring prod_valid picks the wrong lane
  task automatic drive(input logic s, input logic f, input logic [3:0] pv,
                       input logic [6:0] pt, input int ck, input logic [6:0] ct);
    stall = s;
    flush = f;
    prod_valid = pv;
    prod_tag = {NL{pt}};
    cons_valid = '0;
    cons_tag = '0;
    if (ck >= 0) begin
      cons_valid[ck] = 1'b1;
      cons_tag[ck*TW +: TW] = ct;
    end
  endtask

  initial begin
    tbl[0]  = mk(0, 0, 4'b0100, 7'h15,  0, 7'h15,  0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 4'b0000, 7'h15,  0, 7'h15,  0, 1, 0, 2, 1);
    tbl[2]  = mk(0, 0, 4'b0000, 7'h00,  0, 7'h15,  0, 1, 1, 2, 1);
    tbl[3]  = mk(0, 0, 4'b0000, 7'h00, -1, 7'h00,  0, 0, 0, 0, 0);
    tbl[4]  = mk(0, 0, 4'b1000, 7'h33, -1, 7'h00,  0, 0, 0, 0, 0);
    tbl[5]  = mk(0, 0, 4'b0010, 7'h33,  0, 7'h33,  0, 0, 0, 0, 0);
    tbl[6]  = mk(0, 0, 4'b0000, 7'h00, -1, 7'h00,  0, 1, 0, 1, 1);
    tbl[7]  = mk(0, 0, 4'b1000, 7'h7f, 11, 7'h7f,  0, 0, 0, 0, 0);
    tbl[8]  = mk(0, 0, 4'b0000, 7'h00, -1, 7'h00, 11, 1, 0, 3, 1);
    tbl[9]  = mk(0, 0, 4'b0001, 7'h00,  0, 7'h00,  0, 0, 0, 0, 0);
    tbl[10] = mk(0, 0, 4'b0000, 7'h00, -1, 7'h00,  0, 0, 0, 0, 1);
    tbl[11] = mk(0, 0, 4'b0001, 7'h08, -1, 7'h00,  0, 0, 0, 0, 0);
    tbl[12] = mk(1, 0, 4'b0010, 7'h08,  0, 7'h08,  0, 0, 0, 0, 0);
    tbl[13] = mk(1, 0, 4'b0010, 7'h08,  0, 7'h08,  0, 0, 0, 0, 0);
    tbl[14] = mk(0, 0, 4'b0000, 7'h00,  0, 7'h08,  0, 0, 0, 0, 0);
    tbl[15] = mk(1, 0, 4'b0000, 7'h00, -1, 7'h00,  0, 1, 1, 0, 1);
    tbl[16] = mk(0, 0, 4'b0000, 7'h00, -1, 7'h00,  0, 1, 1, 0, 1);
    tbl[17] = mk(0, 0, 4'b0000, 7'h00, -1, 7'h00,  0, 0, 0, 0, 0);
    tbl[18] = mk(0, 0, 4'b0001, 7'h08, -1, 7'h00,  0, 0, 0, 0, 0);
    tbl[19] = mk(1, 1, 4'b0100, 7'h08,  0, 7'h08,  0, 0, 0, 0, 0);
    tbl[20] = mk(0, 0, 4'b0000, 7'h00,  0, 7'h08,  0, 0, 0, 0, 0);
    tbl[21] = mk(0, 0, 4'b0000, 7'h00, -1, 7'h00,  0, 0, 0, 0, 0);

    // Reset held with duplicate producers on every lane
    rst = 1'b1;
    drive(0, 0, 4'b1111, 7'h10, -1, 7'h00);
    step();
    step();
    rst = 1'b0;
    drive(0, 0, 4'b0000, 7'h00, -1, 7'h00);
    step();
    chk("rst_sv0", 0, 32'(sv0), 32'd0);
    chk("rst_sv1", 0, 32'(sv1), 32'd0);
    chk("rst_mh0", 0, 32'(mh0), 32'd0);
    chk("rst_mh1", 0, 32'(mh1), 32'd0);

    // Each row checks the outputs produced by the previous row, then applies its own inputs
    for (int i = 0; i < 22; i++) begin
      chk("sel_valid", i, 32'(sv0), 32'(NOPS'(tbl[i].esv) << tbl[i].ek));
      chk("sel_stage", i, 32'(st0[tbl[i].ek*SB +: SB]), 32'(tbl[i].est));
      chk("sel_lane", i, 32'(ln0[tbl[i].ek*LB +: LB]), 32'(tbl[i].eln));
      chk("multi_hit", i, 32'(mh0), 32'd0);
      chk("z_sel_valid", i, 32'(sv1), 32'(NOPS'(tbl[i].zsv) << tbl[i].ek));
      chk("z_sel_stage", i, 32'(st1[tbl[i].ek*SB +: SB]), 32'(tbl[i].est));
      chk("z_sel_lane", i, 32'(ln1[tbl[i].ek*LB +: LB]), 32'(tbl[i].eln));
      drive(tbl[i].stall, tbl[i].flush, tbl[i].pv, tbl[i].ptag, tbl[i].ck, tbl[i].ctag);
      step();
    end

    // Duplicate tag 0 only counts when zero-tag bypass is enabled
    drive(0, 0, 4'b0011, 7'h00, -1, 7'h00);
    step();
    chk("mh_zero0", 0, 32'(mh0), 32'd0);
    chk("mh_zero1", 0, 32'(mh1), 32'd1);

    // Duplicate nonzero tag: sticky flag, lowest lane wins the select
    drive(0, 0, 4'b0011, 7'h10, 0, 7'h10);
    step();
    chk("mh_set", 0, 32'(mh0), 32'd1);
    chk("mh_sv", 0, 32'(sv0), 32'd1);
    chk("mh_stage", 0, 32'(st0[0 +: SB]), 32'd0);
    chk("mh_lane", 0, 32'(ln0[0 +: LB]), 32'd0);

    drive(0, 1, 4'b0000, 7'h00, -1, 7'h00);
    step();
    chk("mh_after_flush", 0, 32'(mh0), 32'd1);
    chk("sv_after_flush", 0, 32'(sv0), 32'd0);

    drive(0, 0, 4'b0000, 7'h00, -1, 7'h00);
    repeat (3) step();
    chk("mh_hold", 0, 32'(mh0), 32'd1);

    // Mid-operation reset with a pending match in the same cycle
    drive(0, 0, 4'b1000, 7'h20, -1, 7'h00);
    step();
    rst = 1'b1;
    drive(0, 0, 4'b0000, 7'h00, 0, 7'h20);
    step();
    rst = 1'b0;
    drive(0, 0, 4'b0000, 7'h00, -1, 7'h00);
    chk("mid_rst_sv0", 0, 32'(sv0), 32'd0);
    chk("mid_rst_mh0", 0, 32'(mh0), 32'd0);
    chk("mid_rst_mh1", 0, 32'(mh1), 32'd0);
    step();
    chk("post_rst_sv0", 0, 32'(sv0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bypass_select_tracker.md
# bypass_select_tracker

Parametrised bypass-control generator for the register-read/execute boundary. It tracks destination physical-register tags of in-flight producers through a configurable number of result stages (e.g. EX, WB) across a configurable number of producer lanes. Each cycle it compares every consumer source operand against that in-flight set and issues a registered per-operand select: valid, stage index and lane index. It generalises the fixed two-operand, four-stage select encoding to N operands, N stages and N lanes, and adds stall, flush and multi-hit checking.

## Interface
Parameters:
- NUM_LANES, 4, producer lanes writing results into the bypass network
- NUM_STAGES, 2, result stages that can forward; stage 0 is youngest
- NUM_CONSUMERS, 4, consumer slots in register-read
- NUM_OPERANDS, 3, source operands per consumer
- TAG_WIDTH, 7, physical register tag width
- ZERO_TAG_BYPASS, 0, when 0 tag 0 never matches (hard-wired zero register)
- Derived: LANE_BITS = max(1, clog2(NUM_LANES)); STAGE_BITS = max(1, clog2(NUM_STAGES)); NOPS = NUM_CONSUMERS*NUM_OPERANDS

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  freezes all state and outputs
- flush  in  1  invalidates all in-flight producers and selects
- prod_valid  in  NUM_LANES  lane i enters stage 0 next cycle with a register write
- prod_tag  in  NUM_LANES*TAG_WIDTH  destination tag per lane
- cons_valid  in  NOPS  operand k reads a register (index k = consumer*NUM_OPERANDS + operand)
- cons_tag  in  NOPS*TAG_WIDTH  source tag per operand
- sel_valid  out  NOPS  operand k takes bypassed data this cycle
- sel_stage  out  NOPS*STAGE_BITS  source stage of the bypass
- sel_lane  out  NOPS*LANE_BITS  source lane of the bypass
- multi_hit  out  1  sticky: two valid entries in one stage hold the same nonzero tag

## Operation
- State: entry[s][l] = {valid, tag} for s in 0..NUM_STAGES-1, l in 0..NUM_LANES-1.
- Shift, when not stalled: entry[0][l] <= {prod_valid[l], prod_tag[l]}; entry[s][l] <= entry[s-1][l]. Entries leaving stage NUM_STAGES-1 are dropped.
- Lookahead compare: operand k is compared against the set that will occupy stages 0..NUM_STAGES-1 next cycle. That set is the prod_* inputs (next stage 0) plus entry[0..NUM_STAGES-2] (next stages 1..NUM_STAGES-1).
- Match condition: cons_valid[k] & entry valid & tag equal & (ZERO_TAG_BYPASS | tag != 0).
- Priority: the lowest next-stage index wins (youngest value). Within a stage, the lowest lane index wins.
- Registered result per operand:
  - On a match: sel_valid = 1, sel_stage = winning next-stage index, sel_lane = winning lane.
  - On no match: sel_valid = 0, and sel_stage and sel_lane = 0.
- multi_hit is set when any stage of the next-cycle set contains two valid entries with an equal tag. Tag 0 is excluded unless ZERO_TAG_BYPASS is set. multi_hit clears only on rst.
- Stall: entries, sel_* and multi_hit hold. prod_* and cons_* are ignored.
- Flush: next cycle all entry valid bits = 0 and sel_valid = 0. prod_* presented in the flush cycle is discarded. Flush has priority over stall. multi_hit is unaffected.
- Reset: same as flush, and multi_hit = 0. Applies mid-operation with no residual state.

## Timing
- Reset values: sel_valid = 0, sel_stage = 0, sel_lane = 0, multi_hit = 0, all entries invalid.
- Latency: cons_* sampled at edge t gives sel_* valid during cycle t+1. sel_stage refers to stage occupancy during cycle t+1.
- A producer presented in cycle t occupies stage s during cycle t+1+s, for unstalled cycles only.
- A consumer matching a producer presented in the same cycle gets sel_stage = 0 the next cycle.
- After a stall deasserts, the shift resumes from the held state. No entry is duplicated or lost.
- Simultaneous stall+flush: flush behaviour. Simultaneous rst and anything else: reset behaviour.
- Compare logic is a single combinational level before the sel_* registers. There is no combinational path from inputs to outputs.

## Test plan
- Reset: assert rst with prod_valid = all ones for 2 cycles, then release. Required: sel_valid = 0 and multi_hit = 0 on the first cycle after release.
- Stage walk: default params, lane 2 produces tag 0x15 at t, and operand 0 reads 0x15 at t, t+1 and t+2. Required selects:
  - at t+1: stage 0, lane 2
  - at t+2: stage 1, lane 2
  - at t+3: sel_valid[0] = 0
- Priority: tag 0x33 on lane 3 at t and on lane 1 at t+1, consumer reads 0x33 at t+1. Required at t+2: stage 0, lane 1 (the younger producer).
- Zero tag: lane 0 produces tag 0 and an operand reads tag 0. Required: no select. With ZERO_TAG_BYPASS = 1 the same stimulus gives stage 0, lane 0.
- Stall/flush:
  - Producer tag 0x08 at t, stall at t+1 and t+2, then a consumer reads 0x08 at t+3. Required at t+4: stage 1.
  - Repeat with flush at t+1 instead of the stall. Required: no select.
- Multi-hit: lanes 0 and 1 both produce tag 0x10 in one cycle. Required: multi_hit = 1 the next cycle, still set after a flush, and cleared only by rst.
